// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch/decode/execute sequencing controller
//
// Sequences one instruction at a time: fetch from instruction memory, hand the
// latched word to the decoder, wait for the execute stage, then advance pc.
// Faults (illegal opcode, misaligned branch target) park the controller in
// HALT until reset.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   imem_req            fetch request, high only in FETCH
//   imem_addr           fetch address (always equals pc)
//   imem_ack            fetch data valid, honoured only in FETCH
//   imem_rdata          fetched instruction word
//   ir                  latched instruction for the decoder
//   dec_en              decoder enable, high in DECODE and EXEC
//   invalid_instruction decoder illegal-opcode flag, sampled in DECODE
//   ex_done             execute finished, honoured only in EXEC
//   br_taken            branch taken, qualified by ex_done
//   br_target           taken-branch destination
//   pc                  program counter
//   instret             retired-instruction count (wraps)
//   trap                controller halted on a fault
//   trap_cause          01 illegal instruction, 10 misaligned target, 00 none

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dec_en,
  input  logic        invalid_instruction,
  input  logic        ex_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] ir_nxt;
  logic [31:0] instret_nxt;
  logic [1:0]  cause_nxt;
  logic        misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      instret    <= 32'h0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      instret    <= instret_nxt;
      trap_cause <= cause_nxt;
    end
  end

  // A taken branch to a non-word-aligned target is a fault, not a jump.
  assign misaligned = br_taken && (br_target[1:0] != 2'b00);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    instret_nxt = instret;
    cause_nxt   = trap_cause;
    imem_req    = 1'b0;
    dec_en      = 1'b0;
    trap        = 1'b0;
    imem_addr   = pc;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        dec_en = 1'b1;
        if (invalid_instruction) begin
          cause_nxt = CAUSE_ILLEGAL;
          state_nxt = HALT;
        end else begin
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        dec_en = 1'b1;
        if (ex_done) begin
          // The instruction retires even when its branch target faults.
          instret_nxt = instret + 32'd1;
          if (misaligned) begin
            cause_nxt = CAUSE_MISALIGN;
            state_nxt = HALT;
          end else begin
            pc_nxt    = br_taken ? br_target : (pc + 32'd4);
            state_nxt = FETCH;
          end
        end
      end

      HALT: begin
        trap = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard testbench for inst_fetch_ctrl

module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic        dec_en;
  logic        invalid_instruction = 1'b0;
  logic        ex_done = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic        ir_pend = 1'b0;
  logic [31:0] ir_exp = 32'h0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ack            (imem_ack),
    .imem_rdata          (imem_rdata),
    .ir                  (ir),
    .dec_en              (dec_en),
    .invalid_instruction (invalid_instruction),
    .ex_done             (ex_done),
    .br_taken            (br_taken),
    .br_target           (br_target),
    .pc                  (pc),
    .instret             (instret),
    .trap                (trap),
    .trap_cause          (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted fetch against the scoreboard queue,
  // checks the captured ir one cycle later, and checks that a waiting
  // request holds its address.
  always @(negedge clk) begin
    if (!rst_n) begin
      ir_pend   = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (ir_pend) begin
        chk("ir_capture", ir, ir_exp);
        ir_pend = 1'b0;
      end
      if (prev_wait) begin
        chk("req_held", {31'h0, imem_req}, 32'h1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (imem_req && imem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got addr %h expected no fetch", imem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_addr", imem_addr, e.addr);
          ir_exp  = e.data;
          ir_pend = 1'b1;
        end
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got imem_req 0 expected 1 within 50 cycles");
    end
  endtask

  // Answers the pending fetch after dly wait cycles; returns #1 after the
  // accepting edge (controller now in DECODE).
  task automatic serve(input int dly, input logic [31:0] data);
    wait_req();
    chk("dec_en_fetch", {31'h0, dec_en}, 32'h0);
    repeat (dly) begin
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] addr, input logic [31:0] data, input int dly,
                           input logic illegal, input logic br, input logic [31:0] tgt);
    exp_q.push_back('{addr: addr, data: data});
    serve(dly, data);
    chk("dec_en_decode", {31'h0, dec_en}, 32'h1);
    invalid_instruction = illegal;
    @(posedge clk); #1;
    invalid_instruction = 1'b0;
    if (!illegal) begin
      ex_done   = 1'b1;
      br_taken  = br;
      br_target = tgt;
      @(posedge clk); #1;
      ex_done   = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    chk("rst_cause", {30'h0, trap_cause}, 32'h0);
    chk("rst_dec_en", {31'h0, dec_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential run, branch, pc wrap, then misaligned branch halt.
    run_instr(32'h0000_0000, 32'hA000_0001, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h0000_0004, 32'hA000_0002, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h0000_0008, 32'hA000_0003, 0, 1'b0, 1'b0, 32'h0);
    chk("seq_instret", instret, 32'd3);
    chk("seq_trap", {31'h0, trap}, 32'h0);
    chk("seq_pc", pc, 32'h0000_000C);
    run_instr(32'h0000_000C, 32'hA000_0004, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h0000_0010, 32'hA000_0005, 0, 1'b0, 1'b1, 32'h0000_0040);
    chk("br_pc", pc, 32'h0000_0040);
    chk("br_instret", instret, 32'd5);
    run_instr(32'h0000_0040, 32'hA000_0006, 1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run_instr(32'hFFFF_FFFC, 32'hA000_0007, 0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0000_0000);
    run_instr(32'h0000_0000, 32'hA000_0008, 0, 1'b0, 1'b1, 32'h0000_0042);
    chk("mis_trap", {31'h0, trap}, 32'h1);
    chk("mis_cause", {30'h0, trap_cause}, 32'h2);
    chk("mis_pc", pc, 32'h0000_0000);
    chk("mis_instret", instret, 32'd8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1 imem_ack = 1'b0;
    chk("halt_ir", ir, 32'hA000_0008);
    chk("halt_req", {31'h0, imem_req}, 32'h0);
    chk("halt_dec_en", {31'h0, dec_en}, 32'h0);
    chk("halt_pc", pc, 32'h0000_0000);

    // Illegal opcode.
    do_reset();
    run_instr(32'h0000_0000, 32'hB000_0001, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h0000_0004, 32'hB000_0002, 0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("ill_trap", {31'h0, trap}, 32'h1);
    chk("ill_cause", {30'h0, trap_cause}, 32'h1);
    chk("ill_instret", instret, 32'd1);
    chk("ill_req", {31'h0, imem_req}, 32'h0);
    chk("ill_pc", pc, 32'h0000_0004);

    // Slow memory with reset mid-fetch; stray ex_done during fetch ignored.
    do_reset();
    wait_req();
    ex_done   = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0040;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_req", {31'h0, imem_req}, 32'h0);
    chk("mid_pc", pc, 32'h0);
    chk("mid_ir", ir, 32'h0);
    chk("mid_instret", instret, 32'h0);
    chk("mid_trap", {31'h0, trap}, 32'h0);
    chk("mid_cause", {30'h0, trap_cause}, 32'h0);
    chk("mid_dec_en", {31'h0, dec_en}, 32'h0);
    ex_done    = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("late_ack_ir", ir, 32'h0);
    chk("late_ack_req", {31'h0, imem_req}, 32'h1);
    run_instr(32'h0000_0000, 32'hC000_0001, 5, 1'b0, 1'b0, 32'h0);
    chk("slow_instret", instret, 32'd1);
    chk("slow_pc", pc, 32'h0000_0004);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
